// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared types and constants for the rv32 instruction/data SRAM arbiter.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic       PORT_I       = 1'b0;
  localparam logic       PORT_D       = 1'b1;
  localparam logic [3:0] WSTRB_FULL   = 4'hF;
  localparam int         RESP_LATENCY = 2;

  // A request is rejected when it is not word aligned or is a store that enables no bytes.
  function automatic logic is_misaligned(logic [1:0] lsb, logic we, logic [3:0] wstrb);
    return (lsb != 2'b00) || (we && (wstrb == 4'h0));
  endfunction

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Request/response channels of the fetch and data ports plus the SRAM macro pins.
interface rv32_mem_arbiter_if #(parameter int AW = 8);

  logic          i_req_valid;
  logic          i_req_ready;
  logic [31:0]   i_req_addr;
  logic          i_resp_valid;
  logic [31:0]   i_resp_rdata;
  logic          i_resp_err;

  logic          d_req_valid;
  logic          d_req_ready;
  logic [31:0]   d_req_addr;
  logic          d_req_we;
  logic [31:0]   d_req_wdata;
  logic [3:0]    d_req_wstrb;
  logic          d_resp_valid;
  logic [31:0]   d_resp_rdata;
  logic          d_resp_err;

  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    input  sram_rdata,
    output i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err,
    output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    output sram_rdata,
    input  i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/rv32_mem_arbiter_pick.sv
// Grant selection between fetch and data requesters, with a data-streak limiter
// that forces a fetch grant after MAX_D_STREAK data wins against a pending fetch.
module rv32_mem_arb_pick #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic d_valid,
  input  logic idle,
  input  logic fire,
  output logic grant_i,
  output logic grant_d
);

  localparam int            SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [SW-1:0] STREAK_0   = {SW{1'b0}};

  logic [SW-1:0] streak_r;
  logic          force_i_s;

  // Winner select: data wins a tie unless it has used up its streak.
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    force_i_s = (streak_r == STREAK_MAX);
    if (idle && i_valid && d_valid) begin
      grant_i = force_i_s;
      grant_d = !force_i_s;
    end else if (idle) begin
      grant_i = i_valid;
      grant_d = d_valid;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Streak counter: counts data wins only while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_r <= STREAK_0;
    end else if (idle && !i_valid) begin
      streak_r <= STREAK_0;
    end else if (fire && grant_i) begin
      streak_r <= STREAK_0;
    end else if (fire && grant_d && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + SW'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Single-port SRAM shared by fetch and data ports, one transaction per 3 cycles.
// Optional alignment check is compiled in with `define RV32_MEM_ARB_ALIGN_CHECK_EN.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int MEM_WORDS    = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  rv32_mem_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        state_r, state_s;
  logic          grant_i_s, grant_d_s, fire_s;
  logic [31:0]   addr_s, wdata_s;
  logic          we_s, mis_s;
  logic [3:0]    wstrb_s;
  logic          port_r, we_r, mis_r, busy_r;
  logic          sram_en_r;
  logic [3:0]    sram_we_r;
  logic [AW-1:0] sram_addr_r;
  logic [31:0]   sram_wdata_r, i_rdata_s, d_rdata_s;
  logic          i_resp_valid_r, d_resp_valid_r, i_resp_err_r, d_resp_err_r;
  logic          i_rsel_r, d_rsel_r;

  rv32_mem_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.i_req_valid),
    .d_valid (bus.d_req_valid),
    .idle    (state_r == IDLE),
    .fire    (fire_s),
    .grant_i (grant_i_s),
    .grant_d (grant_d_s)
  );

  assign fire_s = grant_i_s | grant_d_s;

  // Next-state logic for the IDLE -> ACCESS -> RESP loop.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (fire_s) state_s = ACCESS; else state_s = IDLE;
      ACCESS:  state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request mux towards the granted port.
  always_comb begin
    addr_s  = bus.i_req_addr;
    we_s    = 1'b0;
    wdata_s = 32'h0;
    wstrb_s = WSTRB_FULL;
    if (grant_d_s) begin
      addr_s  = bus.d_req_addr;
      we_s    = bus.d_req_we;
      wdata_s = bus.d_req_wdata;
      wstrb_s = bus.d_req_wstrb;
    end else begin
      addr_s  = bus.i_req_addr;
      we_s    = 1'b0;
      wdata_s = 32'h0;
      wstrb_s = WSTRB_FULL;
    end
`ifdef RV32_MEM_ARB_ALIGN_CHECK_EN
    mis_s = is_misaligned(addr_s[1:0], we_s, wstrb_s);
`else
    mis_s = 1'b0;
`endif
  end

  // State, latched request and registered SRAM/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      port_r         <= PORT_I;
      we_r           <= 1'b0;
      mis_r          <= 1'b0;
      sram_en_r      <= 1'b0;
      sram_we_r      <= 4'h0;
      sram_addr_r    <= {AW{1'b0}};
      sram_wdata_r   <= 32'h0;
      i_resp_valid_r <= 1'b0;
      d_resp_valid_r <= 1'b0;
      i_resp_err_r   <= 1'b0;
      d_resp_err_r   <= 1'b0;
      i_rsel_r       <= 1'b0;
      d_rsel_r       <= 1'b0;
    end else begin
      state_r        <= state_s;
      busy_r         <= (state_s != IDLE);
      sram_en_r      <= 1'b0;
      sram_we_r      <= 4'h0;
      i_resp_valid_r <= 1'b0;
      d_resp_valid_r <= 1'b0;
      i_resp_err_r   <= 1'b0;
      d_resp_err_r   <= 1'b0;
      i_rsel_r       <= 1'b0;
      d_rsel_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            port_r       <= grant_d_s ? PORT_D : PORT_I;
            we_r         <= we_s;
            mis_r        <= mis_s;
            sram_en_r    <= !mis_s;
            sram_we_r    <= (we_s && !mis_s) ? wstrb_s : 4'h0;
            sram_addr_r  <= addr_s[AW+1:2];
            sram_wdata_r <= wdata_s;
          end
        end
        ACCESS: begin
          i_resp_valid_r <= (port_r == PORT_I);
          d_resp_valid_r <= (port_r == PORT_D);
          i_resp_err_r   <= (port_r == PORT_I) && mis_r;
          d_resp_err_r   <= (port_r == PORT_D) && mis_r;
          i_rsel_r       <= (port_r == PORT_I) && !we_r && !mis_r;
          d_rsel_r       <= (port_r == PORT_D) && !we_r && !mis_r;
        end
        RESP: begin
          port_r <= port_r;
        end
        default: begin
          port_r <= port_r;
        end
      endcase
    end
  end

  // SRAM data only arrives in RESP, so read data is gated by registered selects.
  always_comb begin
    if (i_rsel_r) i_rdata_s = bus.sram_rdata; else i_rdata_s = 32'h0;
    if (d_rsel_r) d_rdata_s = bus.sram_rdata; else d_rdata_s = 32'h0;
  end

  assign bus.i_req_ready  = grant_i_s;
  assign bus.d_req_ready  = grant_d_s;
  assign bus.i_resp_valid = i_resp_valid_r;
  assign bus.d_resp_valid = d_resp_valid_r;
  assign bus.i_resp_err   = i_resp_err_r;
  assign bus.d_resp_err   = d_resp_err_r;
  assign bus.i_resp_rdata = i_rdata_s;
  assign bus.d_resp_rdata = d_rdata_s;
  assign bus.sram_en      = sram_en_r;
  assign bus.sram_we      = sram_we_r;
  assign bus.sram_addr    = sram_addr_r;
  assign bus.sram_wdata   = sram_wdata_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: directed vector table, hand sequences,
// and a randomized run against a word-level memory and arbitration reference model.
module tb_rv32_mem_arbiter;
  import rv32_mem_pkg::*;

  localparam int MEM_WORDS = 256;
  localparam int AW        = 8;
  localparam int MAXS      = 4;

`ifdef RV32_MEM_ARB_ALIGN_CHECK_EN
  localparam logic [31:0] RD_22   = 32'h0;
  localparam logic [31:0] RD_1002 = 32'h0;
`else
  localparam logic [31:0] RD_22   = 32'h1111BEEF;
  localparam logic [31:0] RD_1002 = 32'hA5A5A5A5;
`endif

  typedef struct {
    bit            port;
    logic [31:0]   addr;
    bit            we;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [AW-1:0] exp_idx;
    logic [31:0]   exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  vec_t vecs [15];

  rv32_mem_arbiter_if #(.AW(AW)) bus();

  rv32_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_D_STREAK(MAXS)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM macro model; cleared while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MEM_WORDS; k++) mem[k] <= 32'h0;
    end else if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_we[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= mem[bus.sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit tb_misalign(logic [31:0] addr, bit we, logic [3:0] wstrb);
`ifdef RV32_MEM_ARB_ALIGN_CHECK_EN
    return ((addr % 32'd4) != 32'd0) || (we && (wstrb == 4'h0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic ref_store(input logic [AW-1:0] idx, input logic [31:0] wdata, input logic [3:0] wstrb);
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
  endtask

  // One isolated transaction, checked at grant, ACCESS, RESP and the cycle after.
  task automatic do_txn(input vec_t v, input string tag);
    bit mis;
    int n;
    logic own_rdy, oth_rdy, own_rv, oth_rv, own_err;
    logic [31:0] own_rd;
    mis = tb_misalign(v.addr, v.we, v.wstrb);
    if (v.port) begin
      bus.d_req_valid = 1'b1; bus.d_req_addr = v.addr; bus.d_req_we = v.we;
      bus.d_req_wdata = v.wdata; bus.d_req_wstrb = v.wstrb;
    end else begin
      bus.i_req_valid = 1'b1; bus.i_req_addr = v.addr;
    end
    #1;
    n = 0;
    while (!(v.port ? bus.d_req_ready : bus.i_req_ready) && n < 20) begin
      tick();
      n++;
    end
    own_rdy = v.port ? bus.d_req_ready : bus.i_req_ready;
    oth_rdy = v.port ? bus.i_req_ready : bus.d_req_ready;
    check({tag, "_ready"}, 32'(own_rdy), 32'd1);
    check({tag, "_other_ready"}, 32'(oth_rdy), 32'd0);
    tick();
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b0;
    check({tag, "_sram_en"}, 32'(bus.sram_en), 32'(!mis));
    check({tag, "_sram_we"}, 32'(bus.sram_we), (v.we && !mis) ? 32'(v.wstrb) : 32'd0);
    check({tag, "_sram_addr"}, 32'(bus.sram_addr), 32'(v.exp_idx));
    if (v.we && !mis) check({tag, "_sram_wdata"}, bus.sram_wdata, v.wdata);
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    tick();
    own_rv  = v.port ? bus.d_resp_valid : bus.i_resp_valid;
    oth_rv  = v.port ? bus.i_resp_valid : bus.d_resp_valid;
    own_rd  = v.port ? bus.d_resp_rdata : bus.i_resp_rdata;
    own_err = v.port ? bus.d_resp_err : bus.i_resp_err;
    check({tag, "_resp_valid"}, 32'(own_rv), 32'd1);
    check({tag, "_other_resp"}, 32'(oth_rv), 32'd0);
    check({tag, "_rdata"}, own_rd, v.exp_rdata);
    check({tag, "_err"}, 32'(own_err), 32'(mis));
    tick();
    own_rv = v.port ? bus.d_resp_valid : bus.i_resp_valid;
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_resp_pulse"}, 32'(own_rv), 32'd0);
    if (v.we && !mis) ref_store(v.exp_idx, v.wdata, v.wstrb);
  endtask

  // Both ports pending forever: data may win MAXS times in a row, then fetch.
  task automatic arb_test();
    int k = 0;
    int cyc = 0;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h10;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h20; bus.d_req_we = 1'b0;
    #1;
    while (k < 10 && cyc < 100) begin
      if (bus.i_req_ready || bus.d_req_ready) begin
        check("arb_one_hot", 32'(bus.i_req_ready & bus.d_req_ready), 32'd0);
        check($sformatf("arb_grant%0d_is_fetch", k), 32'(bus.i_req_ready),
              32'((k % (MAXS + 1)) == MAXS));
        k++;
      end
      tick();
      cyc++;
    end
    check("arb_grant_count", 32'(k), 32'd10);
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Reset during ACCESS of a store: the transaction vanishes without a response.
  task automatic reset_mid_access();
    int n = 0;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h30; bus.d_req_we = 1'b1;
    bus.d_req_wdata = 32'h55AA55AA; bus.d_req_wstrb = 4'hF;
    #1;
    while (!bus.d_req_ready && n < 20) begin
      tick();
      n++;
    end
    check("rstmid_ready", 32'(bus.d_req_ready), 32'd1);
    tick();
    bus.d_req_valid = 1'b0;
    check("rstmid_in_access", 32'(bus.sram_en), 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_d_resp", 32'(bus.d_resp_valid), 32'd0);
    check("rstmid_i_resp", 32'(bus.i_resp_valid), 32'd0);
    check("rstmid_sram_en", 32'(bus.sram_en), 32'd0);
    check("rstmid_sram_we", 32'(bus.sram_we), 32'd0);
    check("rstmid_sram_addr", 32'(bus.sram_addr), 32'd0);
    check("rstmid_sram_wdata", bus.sram_wdata, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rdata", bus.d_resp_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("rstmid_no_late_resp", 32'(bus.d_resp_valid), 32'd0);
    for (int k = 0; k < MEM_WORDS; k++) ref_mem[k] = 32'h0;
    do_txn('{1'b1, 32'h10, 1'b1, 32'h00000013, 4'hF, 8'd4, 32'h0}, "post_rst_store");
    do_txn('{1'b0, 32'h10, 1'b0, 32'h0, 4'h0, 8'd4, 32'h00000013}, "post_rst_fetch");
  endtask

  // Random traffic on both ports checked cycle by cycle against a transaction-level model.
  task automatic run_random(input int cycles);
    int busy_left = 0;
    int streak = 0;
    bit gi_prev = 1'b0, gd_prev = 1'b0;
    bit iv, dv, exp_gi, exp_gd;
    bit t_port = 1'b0, t_we = 1'b0, t_mis = 1'b0;
    logic [3:0] t_wstrb = 4'h0;
    logic [31:0] t_wdata = 32'h0, t_ld = 32'h0, t_addr;
    logic [AW-1:0] t_idx = '0;
    for (int c = 0; c < cycles; c++) begin
      if (gi_prev) bus.i_req_valid = 1'b0;
      if (gd_prev) bus.d_req_valid = 1'b0;
      if (!bus.i_req_valid && $urandom_range(0, 2) == 0) begin
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = $urandom;
      end
      if (!bus.d_req_valid && $urandom_range(0, 2) == 0) begin
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = $urandom;
        bus.d_req_we    = 1'($urandom_range(0, 1));
        bus.d_req_wdata = $urandom;
        bus.d_req_wstrb = ($urandom_range(0, 3) == 0) ? WSTRB_FULL : 4'($urandom_range(0, 15));
      end
      #1;
      iv = bus.i_req_valid;
      dv = bus.d_req_valid;
      check("rnd_busy", 32'(busy), 32'(busy_left != 0));
      if (busy_left == 2) begin
        check("rnd_sram_en", 32'(bus.sram_en), 32'(!t_mis));
        check("rnd_sram_we", 32'(bus.sram_we), (t_we && !t_mis) ? 32'(t_wstrb) : 32'd0);
        check("rnd_sram_addr", 32'(bus.sram_addr), 32'(t_idx));
        if (t_we && !t_mis) check("rnd_sram_wdata", bus.sram_wdata, t_wdata);
      end
      check("rnd_i_resp_valid", 32'(bus.i_resp_valid), 32'(busy_left == 1 && !t_port));
      check("rnd_d_resp_valid", 32'(bus.d_resp_valid), 32'(busy_left == 1 && t_port));
      if (busy_left == 1) begin
        check("rnd_rdata", t_port ? bus.d_resp_rdata : bus.i_resp_rdata,
              (t_we || t_mis) ? 32'h0 : t_ld);
        check("rnd_err", 32'(t_port ? bus.d_resp_err : bus.i_resp_err), 32'(t_mis));
      end
      // Fetch wins when alone, or when data has already won MAXS times in a row.
      exp_gi = (busy_left == 0) && iv && (!dv || streak >= MAXS);
      exp_gd = (busy_left == 0) && dv && !exp_gi;
      check("rnd_i_ready", 32'(bus.i_req_ready), 32'(exp_gi));
      check("rnd_d_ready", 32'(bus.d_req_ready), 32'(exp_gd));
      gi_prev = iv && bus.i_req_ready;
      gd_prev = dv && bus.d_req_ready;
      if (busy_left == 0) begin
        if (!iv || exp_gi) streak = 0;
        else if (exp_gd) streak = (streak < MAXS) ? streak + 1 : MAXS;
        if (exp_gi || exp_gd) begin
          t_port  = exp_gd;
          t_we    = exp_gd ? bus.d_req_we : 1'b0;
          t_addr  = exp_gd ? bus.d_req_addr : bus.i_req_addr;
          t_wdata = bus.d_req_wdata;
          t_wstrb = exp_gd ? bus.d_req_wstrb : WSTRB_FULL;
          t_idx   = AW'((t_addr / 32'd4) % MEM_WORDS);
          t_mis   = tb_misalign(t_addr, t_we, t_wstrb);
          t_ld    = ref_mem[t_idx];
          if (t_we && !t_mis) ref_store(t_idx, t_wdata, t_wstrb);
          busy_left = 2;
        end
      end else begin
        busy_left--;
      end
      tick();
    end
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_req_addr = 32'h0;
    bus.d_req_valid = 1'b0; bus.d_req_addr = 32'h0; bus.d_req_we = 1'b0;
    bus.d_req_wdata = 32'h0; bus.d_req_wstrb = 4'h0;
    for (int k = 0; k < MEM_WORDS; k++) ref_mem[k] = 32'h0;

    vecs[0]  = '{1'b1, 32'h020,  1'b1, 32'hDEADBEEF, 4'hF,    8'd8,   32'h0};
    vecs[1]  = '{1'b1, 32'h020,  1'b0, 32'h0,        4'h0,    8'd8,   32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h020,  1'b1, 32'h11111111, 4'hF,    8'd8,   32'h0};
    vecs[3]  = '{1'b1, 32'h020,  1'b1, 32'hDEADBEEF, 4'b0011, 8'd8,   32'h0};
    vecs[4]  = '{1'b1, 32'h020,  1'b0, 32'h0,        4'h0,    8'd8,   32'h1111BEEF};
    vecs[5]  = '{1'b1, 32'h010,  1'b1, 32'h00000013, 4'hF,    8'd4,   32'h0};
    vecs[6]  = '{1'b0, 32'h010,  1'b0, 32'h0,        4'h0,    8'd4,   32'h00000013};
    vecs[7]  = '{1'b1, 32'h3FC,  1'b1, 32'hCAFEF00D, 4'hF,    8'd255, 32'h0};
    vecs[8]  = '{1'b0, 32'h3FC,  1'b0, 32'h0,        4'h0,    8'd255, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 32'h400,  1'b1, 32'hA5A5A5A5, 4'hF,    8'd0,   32'h0};
    vecs[10] = '{1'b1, 32'h000,  1'b0, 32'h0,        4'h0,    8'd0,   32'hA5A5A5A5};
    vecs[11] = '{1'b1, 32'h020,  1'b1, 32'hFFFFFFFF, 4'h0,    8'd8,   32'h0};
    vecs[12] = '{1'b1, 32'h020,  1'b0, 32'h0,        4'h0,    8'd8,   32'h1111BEEF};
    vecs[13] = '{1'b1, 32'h022,  1'b0, 32'h0,        4'h0,    8'd8,   RD_22};
    vecs[14] = '{1'b0, 32'h1002, 1'b0, 32'h0,        4'h0,    8'd0,   RD_1002};

    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sram_en", 32'(bus.sram_en), 32'd0);
    check("rst_sram_we", 32'(bus.sram_we), 32'd0);
    check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_sram_wdata", bus.sram_wdata, 32'd0);
    check("rst_i_resp", 32'(bus.i_resp_valid), 32'd0);
    check("rst_d_resp", 32'(bus.d_resp_valid), 32'd0);
    check("rst_rdata", bus.i_resp_rdata | bus.d_resp_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_no_ready", 32'({bus.i_req_ready, bus.d_req_ready}), 32'd0);

    for (int i = 0; i < 15; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    arb_test();
    reset_mid_access();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
Shares one single-port, word-wide SRAM between the core's instruction-fetch port and its data load/store port.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- One transaction is in flight at a time.
- Data requests win by default; a streak limiter guarantees fetch forward progress.
- Sits between rv32 core front-end/LSU and the unified memory macro.

Parameters:
MEM_WORDS, 256, SRAM depth in 32-bit words; localparam AW = $clog2(MEM_WORDS)
MAX_D_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win (min 1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  32  fetch byte address
i_resp_valid  out  1  one-cycle fetch response pulse
i_resp_rdata  out  32  fetch data, valid with i_resp_valid
i_resp_err  out  1  fetch error flag, valid with i_resp_valid
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  32  data byte address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  32  store data
d_req_wstrb  in  4  store byte enables
d_resp_valid  out  1  one-cycle data response pulse (load data or store ack)
d_resp_rdata  out  32  load data; 0 for stores
d_resp_err  out  1  data error flag
sram_en  out  1  SRAM access enable
sram_we  out  4  SRAM byte write enables
sram_addr  out  AW  SRAM word index
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid one cycle after sram_en
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - State -> IDLE, streak counter -> 0.
  - All registered outputs -> 0: resp_valid, resp_rdata, resp_err, sram_en, sram_we, sram_addr, sram_wdata.
  - Any in-flight transaction is dropped with no response pulse, and no SRAM write is issued after the reset cycle.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Throughput is one transaction per 3 cycles.
- IDLE:
  - *_req_ready is combinational and asserted only in IDLE, to exactly one requester (the grant winner).
  - Handshake completes when valid && ready in cycle N.
  - The arbiter latches port ID, word index = addr[AW+1:2], we, wdata and wstrb; the FSM moves to ACCESS.
- ACCESS (N+1):
  - sram_en = 1; sram_addr, sram_wdata from latch.
  - sram_we = wstrb if store, else 0.
- RESP (N+2):
  - Owning port's resp_valid = 1 for exactly one cycle.
  - rdata = sram_rdata for loads/fetches, 0 for stores.
  - Other port's resp_valid stays 0. Next state is IDLE, so a new grant is possible in cycle N+3.
- Arbitration in IDLE:
  - Only one valid: that port wins.
  - Both valid: data wins unless streak == MAX_D_STREAK, in which case fetch wins.
- Streak counter:
  - Increments on a data grant while i_req_valid = 1.
  - Clears on a fetch grant, or in any IDLE cycle with i_req_valid = 0.
  - Saturates at MAX_D_STREAK.
- Requester rules: hold request fields stable while valid && !ready. The arbiter need not tolerate changes; verification asserts stability.
- Address handling:
  - Upper address bits beyond AW+1 are ignored, so addresses wrap modulo MEM_WORDS*4.
  - addr[1:0] is ignored unless the optional feature is enabled.
- Store with wstrb = 0: completes normally; sram_en = 1, sram_we = 0, ack pulse issued.
- resp_err is always 0 without the optional feature.

Optional Feature:
RV32_MEM_ARB_ALIGN_CHECK_EN
- Defined:
  - A granted request with addr[1:0] != 0 and any store with wstrb == 0 are flagged misaligned.
  - ACCESS drives sram_en = 0 and sram_we = 0.
  - RESP pulses resp_valid with resp_err = 1 and rdata = 0. Latency is unchanged (3 cycles).
- Undefined: no check; *_resp_err tied 0; wstrb = 0 store behaves as above.

Decomposition:
- Package rv32_mem_pkg holds:
  - state enum (IDLE/ACCESS/RESP)
  - port ID constants (PORT_I = 0, PORT_D = 1)
  - WSTRB_FULL = 4'hF
  - the RESP latency constant (2 cycles from accept)
- One sub-module: rv32_mem_arb_pick. It contains the streak counter and the combinational winner select. Inputs: i/d valid, idle, grant-fire. Outputs: grant_i, grant_d.

Test Plan:
- Single fetch of addr 0x10 with mem[4] = 0x00000013 -> i_req_ready at N; sram_en, sram_addr = 4 at N+1; i_resp_valid with rdata 0x00000013 at N+2; busy low at N+3.
- Store 0xDEADBEEF to 0x20 (wstrb F), then load 0x20 -> d ack at N+2 with rdata 0; load returns 0xDEADBEEF. Repeat with wstrb 4'b0011 over 0x11111111 -> 0x1111BEEF.
- i_req_valid and d_req_valid held high continuously, MAX_D_STREAK = 4 -> grant order D,D,D,D,I,D,D,D,D,I…
- Address 0x400 with MEM_WORDS = 256 -> sram_addr = 0 (wrap); address 0x3FC -> sram_addr = 255.
- rst asserted in ACCESS of a store -> no resp pulse; all outputs 0 next cycle; a post-reset fetch is served normally.
- With RV32_MEM_ARB_ALIGN_CHECK_EN, load at 0x22 -> sram_en stays 0; d_resp_valid = 1, d_resp_err = 1, rdata = 0 at N+2.
